// File: rtl/serial_pkg.sv
// Shared types and constants for the serial feed into the sequence detector.
package serial_pkg;

  typedef enum logic {S_IDLE, S_SHIFT} ser_state_t;

  // Level the detector sees on w whenever no word is being shifted out.
  localparam logic IDLE_BIT_DEFAULT = 1'b0;

endpackage

// File: rtl/bit_serializer_piso.sv
// Parallel-load shift register with bit counter; the head bit and a
// last-bit flag come straight from the flops.
module piso_shift #(
  parameter int WIDTH     = 8,
  parameter int MSB_FIRST = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             sout,
  output logic             last
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] sh;
  logic [CW-1:0]    cnt;

  // A load restarts the count; a shift moves the next bit toward the head.
  always_ff @(posedge clk) begin
    if (rst) begin
      sh  <= '0;
      cnt <= '0;
    end else if (load) begin
      sh  <= din;
      cnt <= '0;
    end else if (shift) begin
      if (MSB_FIRST != 0) sh <= {sh[WIDTH-2:0], 1'b0};
      else                sh <= {1'b0, sh[WIDTH-1:1]};
      cnt <= cnt + CW'(1);
    end
  end

  assign sout = (MSB_FIRST != 0) ? sh[WIDTH-1] : sh[0];
  assign last = (cnt == CW'(WIDTH - 1));

endmodule

// File: rtl/bit_serializer.sv
// Word-to-bit serializer feeding the detector input w, with a one-word
// holding buffer so back-to-back words stream without an idle gap.
module bit_serializer
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   MSB_FIRST = 1,
  parameter logic IDLE_BIT  = IDLE_BIT_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             in_ready,
  output logic             w,
  output logic             w_valid,
  output logic             last_bit,
  output logic             busy
);

  ser_state_t       state;
  logic [WIDTH-1:0] hold;
  logic             hold_full;
  logic             sh_out;
  logic             sh_last;
  logic             accept;
  logic             load;
  logic             shift;

  assign accept = in_valid && !hold_full;
  // Loading on the last-bit edge is what makes consecutive words gapless.
  assign load   = hold_full && ((state == S_IDLE) || sh_last);
  assign shift  = (state == S_SHIFT) && !sh_last;

  piso_shift #(
    .WIDTH     (WIDTH),
    .MSB_FIRST (MSB_FIRST)
  ) u_piso (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .shift (shift),
    .din   (hold),
    .sout  (sh_out),
    .last  (sh_last)
  );

  // Accept and load are mutually exclusive since accept needs an empty buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      hold      <= '0;
      hold_full <= 1'b0;
    end else begin
      if (load) begin
        state     <= S_SHIFT;
        hold_full <= 1'b0;
      end else begin
        if (accept) begin
          hold      <= in_data;
          hold_full <= 1'b1;
        end
        if (state == S_SHIFT && sh_last) state <= S_IDLE;
      end
    end
  end

  assign in_ready = !hold_full;
  assign w_valid  = (state == S_SHIFT);
  assign w        = w_valid ? sh_out : IDLE_BIT;
  assign last_bit = w_valid && sh_last;
  assign busy     = w_valid || hold_full;

endmodule
